// File: rtl/cve2v_bench_monitor.sv
// Measures cycles and retired instructions between two back-to-back fence markers and a closing marker.
// Result held in DONE under valid/ready; optional wait for the vector unit to drain before DONE.
module cve2v_bench_monitor #(
  parameter int unsigned CntWidth   = 32,
  parameter logic [31:0] FenceInsn  = 32'h0ff0000f,
  parameter bit          VectorWait = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                rvfi_valid_i,
  input  logic [31:0]         rvfi_insn_i,
  input  logic                rvfi_trap_i,
  input  logic                vec_busy_i,
  output logic                stall_req_o,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [CntWidth-1:0] cycles_o,
  output logic [CntWidth-1:0] instret_o,
  output logic [2:0]          state_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    RUNNING  = 3'd2,
    WAIT_VEC = 3'd3,
    DONE     = 3'd4
  } state_e;

  localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};
  localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cycles_q, cycles_d;
  logic [CntWidth-1:0] instret_q, instret_d;
  logic                stall_q;
  logic                marker;
  logic                retire;

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (v == CntMax) ? v : v + CntOne;
  endfunction

  assign marker = rvfi_valid_i && !rvfi_trap_i && (rvfi_insn_i == FenceInsn);
  assign retire = rvfi_valid_i && !rvfi_trap_i;

  always_comb begin
    state_d   = state_q;
    cycles_d  = cycles_q;
    instret_d = instret_q;
    case (state_q)
      IDLE: begin
        if (marker) state_d = ARMED;
      end
      ARMED: begin
        // Any retirement decides: only an immediately following marker opens the window.
        if (rvfi_valid_i) begin
          if (marker) begin
            state_d   = RUNNING;
            cycles_d  = '0;
            instret_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      RUNNING: begin
        cycles_d = sat_inc(cycles_q);
        if (retire && !marker) instret_d = sat_inc(instret_q);
        if (marker) state_d = VectorWait ? WAIT_VEC : DONE;
      end
      WAIT_VEC: begin
        cycles_d = sat_inc(cycles_q);
        if (!vec_busy_i) state_d = DONE;
      end
      DONE: begin
        if (result_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cycles_q  <= '0;
      instret_q <= '0;
      stall_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycles_q  <= cycles_d;
      instret_q <= instret_d;
      stall_q   <= (state_d == WAIT_VEC);
    end
  end

  assign stall_req_o    = stall_q;
  assign result_valid_o = (state_q == DONE);
  assign cycles_o       = cycles_q;
  assign instret_o      = instret_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_cve2v_bench_monitor.sv
// Directed bench: three monitor instances (no vector wait, vector wait, 4-bit counters) on shared stimulus.
module tb_cve2v_bench_monitor;

  localparam logic [31:0] FENCE = 32'h0ff0000f;
  localparam logic [31:0] ADDI  = 32'h00100093;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] insn = 32'h0;
  logic        trap = 1'b0;
  logic        busy = 1'b0;
  logic        ready = 1'b0;

  logic        stall0, rv0, stall1, rv1, stall2, rv2;
  logic [31:0] cyc0, ins0, cyc1, ins1;
  logic [3:0]  cyc2, ins2;
  logic [2:0]  st0, st1, st2;

  int checks = 0;
  int errors = 0;
  int rv_hi  = 0;

  always #5 clk = ~clk;

  cve2v_bench_monitor #(.CntWidth(32), .FenceInsn(FENCE), .VectorWait(1'b0)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .rvfi_valid_i(valid), .rvfi_insn_i(insn), .rvfi_trap_i(trap),
    .vec_busy_i(busy), .stall_req_o(stall0), .result_valid_o(rv0), .result_ready_i(ready),
    .cycles_o(cyc0), .instret_o(ins0), .state_o(st0));

  cve2v_bench_monitor #(.CntWidth(32), .FenceInsn(FENCE), .VectorWait(1'b1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .rvfi_valid_i(valid), .rvfi_insn_i(insn), .rvfi_trap_i(trap),
    .vec_busy_i(busy), .stall_req_o(stall1), .result_valid_o(rv1), .result_ready_i(ready),
    .cycles_o(cyc1), .instret_o(ins1), .state_o(st1));

  cve2v_bench_monitor #(.CntWidth(4), .FenceInsn(FENCE), .VectorWait(1'b0)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .rvfi_valid_i(valid), .rvfi_insn_i(insn), .rvfi_trap_i(trap),
    .vec_busy_i(busy), .stall_req_o(stall2), .result_valid_o(rv2), .result_ready_i(ready),
    .cycles_o(cyc2), .instret_o(ins2), .state_o(st2));

  typedef struct {
    logic        valid;
    logic [31:0] insn;
    logic        trap;
    logic [2:0]  st;
    logic [31:0] cyc;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] i, input logic t, input logic b, input logic r);
    @(negedge clk);
    valid = v;
    insn  = i;
    trap  = t;
    busy  = b;
    ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Arming rules: marker arms, any other retirement (trapped or not) disarms, idle cycles keep it armed.
    tbl[0] = '{1'b1, FENCE, 1'b0, 3'd1, 32'd0};
    tbl[1] = '{1'b0, FENCE, 1'b0, 3'd1, 32'd0};
    tbl[2] = '{1'b1, ADDI,  1'b0, 3'd0, 32'd0};
    tbl[3] = '{1'b1, FENCE, 1'b1, 3'd0, 32'd0};
    tbl[4] = '{1'b1, FENCE, 1'b0, 3'd1, 32'd0};
    tbl[5] = '{1'b1, ADDI,  1'b1, 3'd0, 32'd0};
    tbl[6] = '{1'b1, FENCE, 1'b0, 3'd1, 32'd0};
    tbl[7] = '{1'b1, ADDI,  1'b0, 3'd0, 32'd0};
    tbl[8] = '{1'b1, FENCE, 1'b0, 3'd1, 32'd0};
    tbl[9] = '{1'b1, FENCE, 1'b0, 3'd2, 32'd0};

    #2;
    chk("reset_state", {29'd0, st0}, 32'd0);
    chk("reset_cycles", cyc0, 32'd0);
    chk("reset_instret", ins0, 32'd0);
    chk("reset_valid", {31'd0, rv0}, 32'd0);
    chk("reset_stall", {31'd0, stall1}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 10; k++) begin
      step(tbl[k].valid, tbl[k].insn, tbl[k].trap, 1'b0, 1'b0);
      chk($sformatf("vec%0d_state0", k), {29'd0, st0}, {29'd0, tbl[k].st});
      chk($sformatf("vec%0d_state1", k), {29'd0, st1}, {29'd0, tbl[k].st});
      chk($sformatf("vec%0d_cycles", k), cyc0, tbl[k].cyc);
    end

    // Measurement window: 20 cycles, 10 counted retirements plus one trapped one.
    for (int i = 0; i < 20; i++) begin
      step((i % 2 == 1) || (i == 4), ADDI, (i == 4), 1'b0, 1'b0);
      if (i == 9) begin
        chk("mid_cycles", cyc0, 32'd10);
        chk("mid_instret", ins0, 32'd5);
        chk("mid_cycles_w4", {28'd0, cyc2}, 32'd10);
      end
    end
    chk("pre_close_state", {29'd0, st0}, 32'd2);

    step(1'b1, FENCE, 1'b0, 1'b1, 1'b0);
    chk("close_state0", {29'd0, st0}, 32'd4);
    chk("close_cycles0", cyc0, 32'd21);
    chk("close_instret0", ins0, 32'd10);
    chk("close_valid0", {31'd0, rv0}, 32'd1);
    chk("close_state1", {29'd0, st1}, 32'd3);
    chk("close_stall1", {31'd0, stall1}, 32'd1);
    chk("close_valid1", {31'd0, rv1}, 32'd0);
    chk("close_cycles1", cyc1, 32'd21);
    chk("sat_state2", {29'd0, st2}, 32'd4);
    chk("sat_cycles2", {28'd0, cyc2}, 32'd15);
    chk("sat_instret2", {28'd0, ins2}, 32'd10);
    rv_hi = rv0 ? 1 : 0;

    // Vector drain on u1 while u0 holds its result with ready low (a marker is injected too).
    for (int i = 1; i <= 7; i++) begin
      step(i == 2, FENCE, 1'b0, i <= 5, 1'b0);
      if (rv0) rv_hi++;
      chk($sformatf("hold%0d_state0", i), {29'd0, st0}, 32'd4);
      chk($sformatf("hold%0d_cycles0", i), cyc0, 32'd21);
      chk($sformatf("hold%0d_instret0", i), ins0, 32'd10);
      chk($sformatf("wait%0d_state1", i), {29'd0, st1}, (i <= 5) ? 32'd3 : 32'd4);
      chk($sformatf("wait%0d_stall1", i), {31'd0, stall1}, (i <= 5) ? 32'd1 : 32'd0);
      chk($sformatf("wait%0d_cycles1", i), cyc1, (i <= 5) ? 32'd21 + i : 32'd27);
      chk($sformatf("wait%0d_instret1", i), ins1, 32'd10);
    end
    chk("rv_high_cycles", rv_hi, 32'd8);

    step(1'b0, ADDI, 1'b0, 1'b0, 1'b1);
    chk("accept_state0", {29'd0, st0}, 32'd0);
    chk("accept_valid0", {31'd0, rv0}, 32'd0);
    chk("idle_hold_cycles0", cyc0, 32'd21);
    chk("accept_state1", {29'd0, st1}, 32'd0);
    chk("idle_hold_cycles1", cyc1, 32'd27);

    // Reset while waiting for the vector unit.
    step(1'b1, FENCE, 1'b0, 1'b0, 1'b0);
    step(1'b1, FENCE, 1'b0, 1'b0, 1'b0);
    chk("rerun_cycles1", cyc1, 32'd0);
    repeat (3) step(1'b0, ADDI, 1'b0, 1'b0, 1'b0);
    chk("rerun_live_cycles1", cyc1, 32'd3);
    step(1'b1, FENCE, 1'b0, 1'b1, 1'b0);
    chk("rerun_state1", {29'd0, st1}, 32'd3);
    step(1'b0, ADDI, 1'b0, 1'b1, 1'b0);
    chk("rerun_stall1", {31'd0, stall1}, 32'd1);
    chk("rerun_wait_cycles1", cyc1, 32'd5);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("arst_stall1", {31'd0, stall1}, 32'd0);
    chk("arst_state1", {29'd0, st1}, 32'd0);
    chk("arst_cycles1", cyc1, 32'd0);
    chk("arst_instret1", ins1, 32'd0);
    chk("arst_valid1", {31'd0, rv1}, 32'd0);
    chk("arst_cycles0", cyc0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, ADDI, 1'b0, 1'b0, 1'b0);
      chk($sformatf("post_rst%0d_valid1", i), {31'd0, rv1}, 32'd0);
      chk($sformatf("post_rst%0d_state1", i), {29'd0, st1}, 32'd0);
      chk($sformatf("post_rst%0d_stall1", i), {31'd0, stall1}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cve2v_bench_monitor.md
CVE2V_BENCH_MONITOR -- requirements
Module: cve2v_bench_monitor

Interface
REQ-001 The module SHALL have parameter CntWidth, default 32, giving the width of the cycle and instret counters.
REQ-002 The module SHALL have parameter FenceInsn, default 32'h0ff0000f, giving the marker instruction encoding.
REQ-003 The module SHALL have parameter VectorWait, default 1'b0; 1 waits for the vector unit to go idle after the closing marker.
REQ-004 clk_i  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-005 rst_ni  input  1  asynchronous, active-low reset.
REQ-006 rvfi_valid_i  input  1  one instruction retires this cycle.
REQ-007 rvfi_insn_i  input  32  encoding of the retiring instruction.
REQ-008 rvfi_trap_i  input  1  the retiring instruction trapped.
REQ-009 vec_busy_i  input  1  vector unit has instructions in flight.
REQ-010 stall_req_o  output  1  request to hold the scalar core in decode.
REQ-011 result_valid_o  output  1  benchmark result available.
REQ-012 result_ready_i  input  1  consumer accepts the result.
REQ-013 cycles_o  output  CntWidth  cycles measured in the window.
REQ-014 instret_o  output  CntWidth  instructions retired in the window.
REQ-015 state_o  output  3  current FSM state: IDLE=0, ARMED=1, RUNNING=2, WAIT_VEC=3, DONE=4.

Function
REQ-016 A "marker" SHALL be a cycle with rvfi_valid_i=1, rvfi_insn_i==FenceInsn and rvfi_trap_i=0; a trapped fence is not a marker.
REQ-017 IDLE -> ARMED on a marker; otherwise IDLE SHALL be held.
REQ-018 In ARMED, the next retirement SHALL decide the transition: a marker -> RUNNING; any other retirement, including a trapped one -> IDLE; no retirement -> stay in ARMED.
REQ-019 On the ARMED->RUNNING transition, cycles and instret SHALL both be cleared to 0.
REQ-020 In RUNNING, cycles SHALL increment by 1 every cycle, including the cycle of the closing marker.
REQ-021 In RUNNING, instret SHALL increment by 1 on each rvfi_valid_i=1 with rvfi_trap_i=0, excluding the closing marker.
REQ-022 RUNNING -> WAIT_VEC on a marker when VectorWait=1; RUNNING -> DONE on a marker when VectorWait=0.
REQ-023 In WAIT_VEC, stall_req_o SHALL be 1 and cycles SHALL increment every cycle; instret SHALL hold.
REQ-024 WAIT_VEC -> DONE in the first cycle vec_busy_i=0; that cycle SHALL still be counted.
REQ-025 stall_req_o SHALL be registered: it rises in the cycle after the entry to WAIT_VEC and falls in the cycle DONE is entered.
REQ-026 In DONE, result_valid_o SHALL be 1 and cycles_o/instret_o SHALL be stable until a cycle with result_valid_o=1 and result_ready_i=1; the state then SHALL go to IDLE.
REQ-027 result_valid_o SHALL NOT depend combinationally on result_ready_i.
REQ-028 Markers and retirements SHALL be ignored in DONE.
REQ-029 cycles_o and instret_o SHALL show the live counters in RUNNING/WAIT_VEC and SHALL hold their last values in IDLE/ARMED until the next clear.
REQ-030 Both counters SHALL saturate at 2^CntWidth-1 and SHALL NOT wrap.
REQ-031 Unused state encodings SHALL recover to IDLE on the next clock.
REQ-032 The block SHALL be synthesizable and SHALL NOT use force/release, $display or file I/O.

Reset
REQ-033 On rst_ni=0, asynchronously: state=IDLE, cycles_o=0, instret_o=0, stall_req_o=0, result_valid_o=0.
REQ-034 Reset asserted in any state, including mid-window or in WAIT_VEC, SHALL abort the measurement; stall_req_o SHALL drop immediately and no result SHALL be produced.

Verification
REQ-035 VectorWait=0; retire marker, marker, 10 non-marker instructions over 20 cycles, then marker -> DONE with instret_o=10 and cycles_o=21 (20 window cycles plus the closing marker cycle).
REQ-036 Retire marker, then an addi, then a marker -> ARMED then IDLE; the second marker re-arms only, with no RUNNING and cycles_o=0.
REQ-037 VectorWait=1; close the window with vec_busy_i=1 for 5 cycles after the marker -> stall_req_o=1 during those cycles, DONE entered on the first vec_busy_i=0 cycle, cycles_o includes the 6 extra cycles.
REQ-038 DONE with result_ready_i=0 for 7 cycles, then 1 -> result_valid_o held high with stable values for 8 cycles; IDLE on the next clock.
REQ-039 CntWidth=4; 20-cycle window -> cycles_o saturates at 15.
REQ-040 rst_ni pulsed low while in WAIT_VEC -> all outputs are 0 within the reset cycle, state_o=0, and no result_valid_o follows.
